// File: rtl/gcd_loader_pkg.sv
// Shared types and widths for the gcd operand loader.
// The nibble counter's top bit selects which operand is being filled.
package gcd_loader_pkg;
    localparam int OPERAND_W           = 16;
    localparam int NIBBLE_W            = 4;
    localparam int NIBBLES_PER_OPERAND = 4;
    localparam int NIBBLES_TOTAL       = 2 * NIBBLES_PER_OPERAND;
    localparam int NIBBLE_CNT_W        = $clog2(NIBBLES_TOTAL);

    typedef enum logic [1:0] {
        COLLECT,
        LOAD,
        BUSY,
        DONE
    } state_t;
endpackage

// File: rtl/gcd_nibble_collector.sv
// Assembles two operands from an LSB-first nibble stream; pulses operands_complete
// combinationally on the final accepted nibble so the FSM can leave COLLECT that same edge.
module gcd_nibble_collector
    import gcd_loader_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 nibble_accept,
    input  logic [NIBBLE_W-1:0]  nibble,
    output logic [OPERAND_W-1:0] value1,
    output logic [OPERAND_W-1:0] value2,
    output logic [OPERAND_W-1:0] value2_next,
    output logic                 operands_complete
);
    localparam int SEL_W = $clog2(NIBBLES_PER_OPERAND);

    logic [NIBBLE_CNT_W-1:0] cnt_q, cnt_d;
    logic [OPERAND_W-1:0]    value1_q, value1_d;
    logic [OPERAND_W-1:0]    value2_q, value2_d;
    logic [SEL_W-1:0]        sel;

    assign sel = cnt_q[SEL_W-1:0];

    always_comb begin
        cnt_d    = cnt_q;
        value1_d = value1_q;
        value2_d = value2_q;
        if (nibble_accept) begin
            cnt_d = cnt_q + NIBBLE_CNT_W'(1);
            if (!cnt_q[NIBBLE_CNT_W-1]) begin
                value1_d[sel*NIBBLE_W +: NIBBLE_W] = nibble;
            end else begin
                value2_d[sel*NIBBLE_W +: NIBBLE_W] = nibble;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            value1_q <= '0;
            value2_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            value1_q <= value1_d;
            value2_q <= value2_d;
        end
    end

    assign value1            = value1_q;
    assign value2            = value2_q;
    // The zero shortcut needs operand B including the nibble landing this cycle.
    assign value2_next       = value2_d;
    assign operands_complete = nibble_accept && (&cnt_q);
endmodule

// File: rtl/gcd_operand_loader.sv
// Feeds the gcd core: collects operands, strobes a load, waits (bounded) for the result,
// holds it until acked. Zero operand A bypasses the core since it would never terminate.
module gcd_operand_loader
    import gcd_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [NIBBLE_W-1:0]  in_nibble,
    output logic                 in_ready,
    output logic [OPERAND_W-1:0] io_value1,
    output logic [OPERAND_W-1:0] io_value2,
    output logic                 io_loadingValues,
    input  logic [OPERAND_W-1:0] io_outputGCD,
    input  logic                 io_outputValid,
    output logic [OPERAND_W-1:0] result,
    output logic                 result_valid,
    output logic                 result_error,
    input  logic                 result_ack,
    output logic                 busy
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t               state_q, state_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [OPERAND_W-1:0] result_q, result_d;
    logic                 result_error_q, result_error_d;
    logic                 result_valid_q, result_valid_d;
    logic                 loading_q, loading_d;

    logic                 nibble_accept;
    logic                 operands_complete;
    logic [OPERAND_W-1:0] value2_next;

    assign in_ready      = (state_q == COLLECT);
    assign busy          = (state_q != COLLECT);
    assign nibble_accept = in_valid && in_ready;

    gcd_nibble_collector u_collector (
        .clock             (clock),
        .reset             (reset),
        .nibble_accept     (nibble_accept),
        .nibble            (in_nibble),
        .value1            (io_value1),
        .value2            (io_value2),
        .value2_next       (value2_next),
        .operands_complete (operands_complete)
    );

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        result_d       = result_q;
        result_error_d = result_error_q;
        case (state_q)
            COLLECT: begin
                if (operands_complete) begin
                    if (io_value1 == '0) begin
                        state_d        = DONE;
                        result_d       = value2_next;
                        result_error_d = 1'b0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                // Core valid still reflects its previous run here, so it is not looked at.
                state_d = BUSY;
                tmo_d   = '0;
            end
            BUSY: begin
                if (io_outputValid) begin
                    state_d        = DONE;
                    result_d       = io_outputGCD;
                    result_error_d = 1'b0;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d        = DONE;
                    result_d       = '0;
                    result_error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        loading_d      = (state_d == LOAD);
        result_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= COLLECT;
            tmo_q          <= '0;
            result_q       <= '0;
            result_error_q <= 1'b0;
            result_valid_q <= 1'b0;
            loading_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            result_q       <= result_d;
            result_error_q <= result_error_d;
            result_valid_q <= result_valid_d;
            loading_q      <= loading_d;
        end
    end

    assign io_loadingValues = loading_q;
    assign result           = result_q;
    assign result_valid     = result_valid_q;
    assign result_error     = result_error_q;
endmodule

// File: tb/tb_gcd_operand_loader.sv
// Directed bench for gcd_operand_loader with a behavioural subtractive gcd core.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_gcd_operand_loader;
    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_nibble;
    logic        in_ready;
    logic [15:0] io_value1, io_value2;
    logic        io_loadingValues;
    logic [15:0] io_outputGCD;
    logic        io_outputValid;
    logic [15:0] result;
    logic        result_valid;
    logic        result_error;
    logic        result_ack;
    logic        busy;

    logic        stub_dead;
    logic [15:0] core_x, core_y;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    gcd_operand_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_nibble        (in_nibble),
        .in_ready         (in_ready),
        .io_value1        (io_value1),
        .io_value2        (io_value2),
        .io_loadingValues (io_loadingValues),
        .io_outputGCD     (io_outputGCD),
        .io_outputValid   (io_outputValid),
        .result           (result),
        .result_valid     (result_valid),
        .result_error     (result_error),
        .result_ack       (result_ack),
        .busy             (busy)
    );

    // Subtractive gcd core sharing the loader's reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_x <= '0;
            core_y <= '0;
        end else if (io_loadingValues) begin
            core_x <= io_value1;
            core_y <= io_value2;
        end else if (core_x > core_y) begin
            core_x <= core_x - core_y;
        end else begin
            core_y <= core_y - core_x;
        end
    end
    assign io_outputGCD   = core_x;
    assign io_outputValid = (core_y == 16'd0) && !stub_dead;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_operands(input logic [15:0] a, input logic [15:0] b, input bit gap);
        for (int k = 0; k < 8; k++) begin
            if (gap && (k % 2 == 1)) begin
                in_valid = 1'b0;
                @(negedge clock);
            end
            in_valid  = 1'b1;
            in_nibble = (k < 4) ? a[4*k +: 4] : b[4*(k-4) +: 4];
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n = 0;
        while (!result_valid && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk(tag, result_valid, 1);
    endtask

    task automatic do_ack(input string tag);
        result_ack = 1'b1;
        @(negedge clock);
        result_ack = 1'b0;
        chk({tag, "_valid_low"}, result_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_loading"}, io_loadingValues, 0);
        chk({tag, "_value1"}, io_value1, 0);
        chk({tag, "_value2"}, io_value2, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result_error"}, result_error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_nibble  = 4'h0;
        result_ack = 1'b0;
        stub_dead  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_values("rst");

        // A = 12, B = 18 -> 6; load pulse exactly one cycle after the last nibble
        send_operands(16'd12, 16'd18, 1'b0);
        chk("t1_load_n1", io_loadingValues, 1);
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 0);
        @(negedge clock);
        chk("t1_load_n2", io_loadingValues, 0);
        chk("t1_value1", io_value1, 16'd12);
        chk("t1_value2", io_value2, 16'd18);
        wait_valid("t1_wait", 20);
        chk("t1_result", result, 16'd6);
        chk("t1_error", result_error, 0);
        repeat (3) @(negedge clock);
        chk("t1_hold_valid", result_valid, 1);
        chk("t1_hold_result", result, 16'd6);
        do_ack("t1_ack");

        // A = 0, B = 0x35 -> shortcut, valid in N+1, no load pulse
        send_operands(16'h0000, 16'h0035, 1'b0);
        chk("t2_no_load", io_loadingValues, 0);
        chk("t2_valid_n1", result_valid, 1);
        chk("t2_result", result, 16'h0035);
        chk("t2_error", result_error, 0);
        @(negedge clock);
        chk("t2_no_load_later", io_loadingValues, 0);
        do_ack("t2_ack");
        chk("t2_result_held", result, 16'h0035);

        // A = 7, B = 0 -> 7, valid two cycles after the load pulse
        send_operands(16'd7, 16'd0, 1'b0);
        chk("t3_load", io_loadingValues, 1);
        @(negedge clock);
        chk("t3_valid_n2", result_valid, 0);
        @(negedge clock);
        chk("t3_valid_n3", result_valid, 1);
        chk("t3_result", result, 16'd7);
        do_ack("t3_ack");

        // Both zero -> result 0, no error
        send_operands(16'd0, 16'd0, 1'b0);
        chk("t4_valid", result_valid, 1);
        chk("t4_result", result, 16'd0);
        chk("t4_error", result_error, 0);
        do_ack("t4_ack");

        // Dead core -> timeout: valid exactly TMO+1 cycles after LOAD
        stub_dead = 1'b1;
        send_operands(16'd12, 16'd18, 1'b0);
        chk("t5_load", io_loadingValues, 1);
        repeat (TMO) @(negedge clock);
        chk("t5_valid_early", result_valid, 0);
        @(negedge clock);
        chk("t5_valid", result_valid, 1);
        chk("t5_result", result, 16'd0);
        chk("t5_error", result_error, 1);
        stub_dead = 1'b0;
        do_ack("t5_ack");

        // Gapped stream, stray nibbles and an early ack while not in DONE
        send_operands(16'd9, 16'd21, 1'b1);
        chk("t6_load", io_loadingValues, 1);
        in_valid   = 1'b1;
        in_nibble  = 4'hF;
        result_ack = 1'b1;
        @(negedge clock);
        result_ack = 1'b0;
        chk("t6_busy_after_ack", busy, 1);
        chk("t6_in_ready_busy", in_ready, 0);
        wait_valid("t6_wait", 20);
        chk("t6_result", result, 16'd3);
        chk("t6_error", result_error, 0);
        @(negedge clock);
        chk("t6_in_ready_done", in_ready, 0);
        chk("t6_value1", io_value1, 16'd9);
        chk("t6_value2", io_value2, 16'd21);
        in_valid = 1'b0;
        do_ack("t6_ack");

        // Reset mid-BUSY, then a clean run
        send_operands(16'd12, 16'd18, 1'b0);
        @(negedge clock);
        chk("t7_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("t7_rst");
        reset = 1'b0;
        @(negedge clock);
        chk("t7_in_ready", in_ready, 1);
        send_operands(16'd12, 16'd18, 1'b0);
        wait_valid("t7_wait", 20);
        chk("t7_result", result, 16'd6);
        chk("t7_error", result_error, 0);
        do_ack("t7_ack");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
